freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 29 ++
 rtl/freq_meter_edge.sv | 27 ++
 rtl/freq_meter.sv | 164 ++++++++++++++++
 tb/tb_freq_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        GATE = 2'd2
    } state_e;

    localparam int unsigned GATE_DIV_0 = 1;
    localparam int unsigned GATE_DIV_1 = 10;
    localparam int unsigned GATE_DIV_2 = 100;
    localparam int unsigned GATE_DIV_3 = 1000;

    localparam int unsigned BYTE_MAX = 255;

    // Gate length in clk cycles for a given selector. Each arm divides a
    // constant by a constant, so this folds to a 4-way mux of literals.
    function automatic int unsigned gate_len_of(input logic [1:0] gate_sel,
                                                input int unsigned gate_cycles);
        case (gate_sel)
            2'd0:    return gate_cycles / GATE_DIV_0;
            2'd1:    return gate_cycles / GATE_DIV_1;
            2'd2:    return gate_cycles / GATE_DIV_2;
            default: return gate_cycles / GATE_DIV_3;
        endcase
    endfunction

endpackage

// File: rtl/freq_meter_edge.sv
// Synchronizer chain plus rising-edge detect for an asynchronous pin.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the metastability flops, then one delay flop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over a fixed window of
// clk cycles and publishes the count, back-to-back, while enable is high.
//
// state | meaning
// IDLE  | not measuring, counters held at zero
// SYNC  | flushing stale synchronizer contents, rise ignored
// GATE  | counting rises; terminal cycle publishes and restarts the window
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       gate_sel,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic [7:0]       freq_byte,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [SW-1:0]    SYNC_LAST  = SW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] BYTE_MAX_W = CNT_W'(BYTE_MAX);

    state_e           state_q, state_d;
    logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [GW-1:0]    gate_last_q, gate_last_d, gate_last_sel;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_close;
    logic             ovf_q, ovf_d, ovf_close;
    logic [CNT_W-1:0] freq_count_q, freq_count_d;
    logic [7:0]       freq_byte_q, freq_byte_d;
    logic             count_valid_q, count_valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .sig_i   (sig_in),
        .rise_o  (rise)
    );

    // Last gate_cnt value of a window, taken from the live selector.
    assign gate_last_sel = GW'(gate_len_of(gate_sel, GATE_CYCLES) - 1);

    // Edge count including this cycle's rise, saturating at all-ones.
    always_comb begin
        edge_close = edge_cnt_q;
        ovf_close  = ovf_q;
        if (rise) begin
            if (&edge_cnt_q) ovf_close  = 1'b1;
            else             edge_close = edge_cnt_q + CNT_W'(1);
        end
    end

    // Next-state, counter and publish logic.
    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        gate_cnt_d    = gate_cnt_q;
        gate_last_d   = gate_last_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_d         = ovf_q;
        freq_count_d  = freq_count_q;
        freq_byte_d   = freq_byte_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                sync_cnt_d = '0;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_d    = IDLE;
                    sync_cnt_d = '0;
                end else if (sync_cnt_q == SYNC_LAST) begin
                    state_d     = GATE;
                    sync_cnt_d  = '0;
                    gate_last_d = gate_last_sel;
                    gate_cnt_d  = '0;
                    edge_cnt_d  = '0;
                    ovf_d       = 1'b0;
                end else begin
                    sync_cnt_d = sync_cnt_q + SW'(1);
                end
            end
            GATE: begin
                if (!enable) begin
                    // Window discarded; published outputs keep their values.
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end else if (gate_cnt_q == gate_last_q) begin
                    freq_count_d  = edge_close;
                    freq_byte_d   = (edge_close > BYTE_MAX_W) ? 8'(BYTE_MAX) : edge_close[7:0];
                    overflow_d    = ovf_close;
                    count_valid_d = 1'b1;
                    gate_cnt_d    = '0;
                    edge_cnt_d    = '0;
                    ovf_d         = 1'b0;
                    gate_last_d   = gate_last_sel;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    edge_cnt_d = edge_close;
                    ovf_d      = ovf_close;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_cnt_q    <= '0;
            gate_cnt_q    <= '0;
            gate_last_q   <= '0;
            edge_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            freq_count_q  <= '0;
            freq_byte_q   <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            gate_cnt_q    <= gate_cnt_d;
            gate_last_q   <= gate_last_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_q         <= ovf_d;
            freq_count_q  <= freq_count_d;
            freq_byte_q   <= freq_byte_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign freq_count  = freq_count_q;
    assign freq_byte   = freq_byte_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit and 8-bit counters) share one
// stimulus stream and are checked every cycle against a window-level model.
module tb_freq_meter;

    localparam int GC       = 1000;
    localparam int SYNC_LAT = 3;       // cycles between enable sampled and first gate cycle
    localparam int PIPE     = 2;       // pin sample to counted rise, in edges

    logic        clk = 1'b0;
    logic        reset, enable, sig_in;
    logic [1:0]  gate_sel;

    logic [31:0] fc32;
    logic [7:0]  fb32, fc8, fb8;
    logic        cv32, ov32, busy32, cv8, ov8, busy8;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .reset(reset), .enable(enable), .gate_sel(gate_sel), .sig_in(sig_in),
        .freq_count(fc32), .freq_byte(fb32), .count_valid(cv32), .overflow(ov32), .busy(busy32)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .gate_sel(gate_sel), .sig_in(sig_in),
        .freq_count(fc8), .freq_byte(fb8), .count_valid(cv8), .overflow(ov8), .busy(busy8)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int window_len(input logic [1:0] g);
        int div;
        div = 1;
        for (int i = 0; i < int'(g); i++) div = div * 10;
        return GC / div;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- behavioural model ----------------
    // Pin history: a rise is counted at edge n when the pin was high at
    // sample n-PIPE and low at sample n-PIPE-1.
    bit hist [0:PIPE];
    int m_since = -1;       // edges since enable was first seen high, -1 when idle
    int m_pos = 0, m_len = 0, m_cnt = 0;
    int e_pub = 0;
    bit e_valid = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin : model
        bit rise;
        rise = hist[PIPE-1] & ~hist[PIPE];
        for (int i = PIPE; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
        e_valid = 1'b0;
        if (reset) begin
            for (int i = 0; i <= PIPE; i++) hist[i] = 1'b0;
            m_since = -1;
            e_pub   = 0;
        end else if (!enable) begin
            m_since = -1;
        end else if (m_since < 0) begin
            m_since = 0;
        end else if (m_since < SYNC_LAT) begin
            m_since++;
            if (m_since == SYNC_LAT) begin
                m_len = window_len(gate_sel);
                m_pos = 0;
                m_cnt = 0;
            end
        end else begin
            m_pos++;
            m_cnt += int'(rise);
            if (m_pos == m_len) begin
                e_pub   = m_cnt;
                e_valid = 1'b1;
                m_cnt   = 0;
                m_pos   = 0;
                m_len   = window_len(gate_sel);
            end
        end
        e_busy = (m_since >= 0);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("fc32",   fc32,   e_pub);
            chk("fb32",   fb32,   sat(e_pub, 255));
            chk("ov32",   ov32,   0);
            chk("cv32",   cv32,   e_valid);
            chk("busy32", busy32, e_busy);
            chk("fc8",    fc8,    sat(e_pub, 255));
            chk("fb8",    fb8,    sat(e_pub, 255));
            chk("ov8",    ov8,    (e_pub > 255) ? 1 : 0);
            chk("cv8",    cv8,    e_valid);
            chk("busy8",  busy8,  e_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    int ph = 0;

    task automatic drive1(input int period);
        if (period == 0) sig_in = 1'b0;
        else             sig_in = ((ph % period) < (period / 2));
        ph++;
        @(negedge clk);
    endtask

    task automatic run_cv(input int period, output int cyc);
        bit found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 5000) begin
            drive1(period);
            cyc++;
            if (cv32) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cv_timeout: got no count_valid expected one within 5000 cycles");
        end
    endtask

    function automatic bit pin_at(input int j);
        int k;
        k = j + 3;  // value driven now is sampled next edge, counted PIPE edges later
        if (k >= 3 && k <= 993 && (k - 3) % 10 == 0) return 1'b1;
        if (k == 1000) return 1'b1;
        if (k >= 1005 && k <= 1995 && (k - 1005) % 10 == 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int cyc, saved, seen;
        int q[$];
        int r;

        reset = 1'b1; enable = 1'b0; gate_sel = 2'd0; sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_fc",   fc32,   0);
        chk("rst_busy", busy32, 0);
        chk("rst_cv",   cv32,   0);
        reset = 1'b0;

        // Period 10, full gate.
        enable = 1'b1;
        run_cv(10, cyc);
        chk("first_lat", cyc, 1004);
        chk("p10_fc", fc32, 100);
        run_cv(10, cyc);
        chk("p10_gap", cyc, 1000);
        chk("p10_fc2", fc32, 100);
        chk("p10_fb",  fb32, 100);
        chk("p10_ov",  ov32, 0);

        // gate_sel=1, then switch to 2 mid-window.
        gate_sel = 2'd1;
        run_cv(10, cyc);
        chk("sel1_old", fc32, 100);
        run_cv(10, cyc);
        chk("sel1_gap", cyc, 100);
        chk("sel1_fc",  fc32, 10);
        repeat (50) drive1(10);
        gate_sel = 2'd2;
        run_cv(10, cyc);
        chk("sel_mid_fc", fc32, 10);
        run_cv(10, cyc);
        chk("sel2_gap", cyc, 10);
        chk("sel2_fc",  fc32, 1);

        // Period 2: saturation of byte view and of the 8-bit counter.
        gate_sel = 2'd0;
        run_cv(2, cyc);
        run_cv(2, cyc);
        chk("p2_fc32", fc32, 500);
        chk("p2_fb32", fb32, 255);
        chk("p2_ov32", ov32, 0);
        chk("p2_fc8",  fc8,  255);
        chk("p2_ov8",  ov8,  1);
        run_cv(10, cyc);
        run_cv(10, cyc);
        chk("rec_fc8", fc8, 100);
        chk("rec_ov8", ov8, 0);

        // Drop enable mid-gate, then re-enable.
        run_cv(10, cyc);
        repeat (500) drive1(10);
        saved = fc32;
        enable = 1'b0;
        drive1(10);
        chk("drop_busy", busy32, 0);
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            drive1(10);
            if (cv32) seen++;
        end
        chk("drop_cv", seen, 0);
        chk("drop_hold", fc32, saved);
        enable = 1'b1;
        run_cv(10, cyc);
        chk("reen_lat", cyc, 1004);
        chk("reen_fc",  fc32, 100);

        // One-cycle reset mid-gate with enable held high.
        repeat (300) drive1(10);
        reset = 1'b1;
        drive1(10);
        chk("mrst_fc32", fc32, 0);
        chk("mrst_fb32", fb32, 0);
        chk("mrst_busy", busy32, 0);
        chk("mrst_fc8",  fc8, 0);
        chk("mrst_ov8",  ov8, 0);
        reset = 1'b0;
        run_cv(10, cyc);
        chk("mrst_lat", cyc, 1004);
        chk("mrst_res", fc32, 100);

        // Rise landing on the terminal cycle.
        run_cv(0, cyc);
        run_cv(0, cyc);
        for (int j = 0; j <= 2002; j++) begin
            if (j > 0 && cv32) q.push_back(int'(fc32));
            sig_in = pin_at(j);
            @(negedge clk);
        end
        chk("term_n", q.size(), 2);
        if (q.size() == 2) begin
            chk("term_w1", q[0], 101);
            chk("term_w2", q[1], 100);
        end

        // Randomized traffic: random pin, selector changes, enable drops, resets.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 4) gate_sel = 2'($urandom_range(0, 3));
            enable = (r < 990);
            reset  = (r == 777);
            sig_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        reset = 1'b0;
        enable = 1'b1;
        repeat (20) @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
